// File: rtl/mem_model.sv
// Single-port synchronous RAM with shared address and registered read.
// Reset loads every word with INIT_VALUE; reads see old data on same-cycle writes.
module mem_model #(
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage: reset fill, else write on wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT_VALUE;
      end
    end else if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: samples pre-write contents, holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: tb/tb_mem_model.sv
// Self-checking bench for mem_model.
// Directed scenarios plus a randomized run against an array model.
module tb_mem_model;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [4];
  logic [7:0] ref_rdata;

  mem_model dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  // One clock cycle; the model follows the behavioural rules.
  task automatic step(input logic r, input logic w, input logic rd,
                      input logic [1:0] a, input logic [7:0] d);
    reset = r;
    wr_en = w;
    rd_en = rd;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
      ref_rdata = 8'h00;
    end else begin
      if (rd) ref_rdata = ref_mem[a];
      if (w)  ref_mem[a] = d;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 2'd1, 8'h3C);
    step(1'b1, 1'b1, 1'b1, 2'd2, 8'hC3);
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h exp %h", rdata, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'(i), 8'h00);
      checks++;
      if (rdata !== 8'hFF) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h exp %h", i, rdata, 8'hFF);
      end
    end
  endtask

  task automatic test_single_write();
    step(1'b0, 1'b1, 1'b0, 2'd2, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_read2 got %h exp %h", rdata, 8'hA5);
    end
    step(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    checks++;
    if (rdata !== 8'hFF) begin
      errors++;
      $display("FAIL untouched1 got %h exp %h", rdata, 8'hFF);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'(17 * (i + 1));
      step(1'b0, 1'b1, 1'b0, 2'(i), v);
    end
    for (int i = 0; i < 4; i++) begin
      v = 8'(17 * (i + 1));
      step(1'b0, 1'b0, 1'b1, 2'(i), 8'h00);
      checks++;
      if (rdata !== v) begin
        errors++;
        $display("FAIL b2b_read[%0d] got %h exp %h", i, rdata, v);
      end
    end
  endtask

  task automatic test_read_before_write();
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'h5A);
    checks++;
    if (rdata !== 8'h44) begin
      errors++;
      $display("FAIL rbw_old got %h exp %h", rdata, 8'h44);
    end
    step(1'b0, 1'b0, 1'b1, 2'd3, 8'h00);
    checks++;
    if (rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rbw_new got %h exp %h", rdata, 8'h5A);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    checks++;
    if (rdata !== 8'h22) begin
      errors++;
      $display("FAIL hold_read got %h exp %h", rdata, 8'h22);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'($urandom_range(3)), 8'($urandom));
      checks++;
      if (rdata !== 8'h22) begin
        errors++;
        $display("FAIL hold[%0d] got %h exp %h", i, rdata, 8'h22);
      end
    end
  endtask

  task automatic test_reset_after_writes();
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 2'd0, 8'h99);
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_rdata got %h exp %h", rdata, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'(i), 8'h00);
      checks++;
      if (rdata !== 8'hFF) begin
        errors++;
        $display("FAIL rst_read[%0d] got %h exp %h", i, rdata, 8'hFF);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(24) == 0);
      step(r, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      checks++;
      if (rdata !== ref_rdata) begin
        errors++;
        $display("FAIL rand[%0d] got %h exp %h", n, rdata, ref_rdata);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'(i), 8'h00);
      checks++;
      if (rdata !== ref_mem[i]) begin
        errors++;
        $display("FAIL rand_final[%0d] got %h exp %h", i, rdata, ref_mem[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    ref_rdata = 8'h00;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_before_write();
    test_hold();
    test_reset_after_writes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
